// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback stage.
// Imported by writeback_stage and ret_pop_fsm.
package wb_pkg;

  localparam int DATA_W  = 16;
  localparam int PC_W    = 32;
  localparam int RADDR_W = 3;
  localparam int FLAG_W  = 3;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_IN,
    WB_IMM
  } wb_src_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOW,
    WAIT_FLAGS
  } wb_state_e;

endpackage

// File: rtl/ret_pop_fsm.sv
// RET/RTI pop-assembly FSM.
// Rebuilds the return PC and flags from 16-bit pops.
module ret_pop_fsm #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int PC_W   = wb_pkg::PC_W,
  parameter int FLAG_W = wb_pkg::FLAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_rti,
  input  logic              pop_word,
  input  logic [DATA_W-1:0] mem_data,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_value,
  output logic              flags_restore,
  output logic [FLAG_W-1:0] flags_value,
  output logic              busy,
  output logic              seq_done
);

  import wb_pkg::*;

  wb_state_e         state;
  logic [DATA_W-1:0] pc_hi;
  logic              is_rti;

  assign busy = (state != IDLE);

  // Last word of a sequence: feeds the retire counter.
  assign seq_done = pop_word &&
    ((state == WAIT_LOW && !is_rti) ||
     (state == WAIT_FLAGS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pc_hi         <= '0;
      is_rti        <= 1'b0;
      pc_load       <= 1'b0;
      flags_restore <= 1'b0;
      pc_value      <= '0;
      flags_value   <= '0;
    end else begin
      pc_load       <= 1'b0;
      flags_restore <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            pc_hi  <= mem_data;
            is_rti <= start_rti;
            state  <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (pop_word) begin
            pc_value <= {pc_hi, mem_data};
            if (is_rti) begin
              state <= WAIT_FLAGS;
            end else begin
              pc_load <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        WAIT_FLAGS: begin
          if (pop_word) begin
            flags_value   <= mem_data[FLAG_W-1:0];
            flags_restore <= 1'b1;
            pc_load       <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/var_reg.sv
// Plain enabled holding register.
// Synchronous active-high reset to zero.
module var_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: rf write port, RET/RTI return, stall.
// Optional retire counter under WB_RETIRE_CNT_EN.
module writeback_stage #(
  parameter int DATA_W  = wb_pkg::DATA_W,
  parameter int PC_W    = wb_pkg::PC_W,
  parameter int RADDR_W = wb_pkg::RADDR_W,
  parameter int FLAG_W  = wb_pkg::FLAG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_valid,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] wb_rdst,
  input  logic [1:0]         wb_src_select,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic [DATA_W-1:0]  in_port,
  input  logic [DATA_W-1:0]  immediate,
  input  logic               wb_ret,
  input  logic               wb_rti,
  input  logic               wb_pop_word,
  output logic               rf_write_en,
  output logic [RADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0]  rf_write_data,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_value,
  output logic               flags_restore,
  output logic [FLAG_W-1:0]  flags_value,
  output logic               wb_busy,
  output logic [31:0]        retired_count
);

  import wb_pkg::*;

  logic              accept;
  logic              seq_start;
  logic              normal;
  logic [DATA_W-1:0] wr_data;

  // Beats arriving while a return is in flight are dropped.
  assign accept    = wb_valid && !wb_busy;
  assign seq_start = accept && (wb_ret || wb_rti);
  assign normal    = accept && !(wb_ret || wb_rti);

  always_comb begin
    wr_data = alu_result;
    unique case (wb_src_e'(wb_src_select))
      WB_ALU:  wr_data = alu_result;
      WB_MEM:  wr_data = mem_data;
      WB_IN:   wr_data = in_port;
      WB_IMM:  wr_data = immediate;
      default: wr_data = alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      rf_write_en <= 1'b0;
    else
      rf_write_en <= normal && wb_reg_write;
  end

  var_reg #(.W(RADDR_W)) u_addr (
    .clk   (clk),
    .reset (reset),
    .en    (normal),
    .d     (wb_rdst),
    .q     (rf_write_addr)
  );

  var_reg #(.W(DATA_W)) u_data (
    .clk   (clk),
    .reset (reset),
    .en    (normal),
    .d     (wr_data),
    .q     (rf_write_data)
  );

`ifdef WB_RETIRE_CNT_EN
  logic seq_done;
`endif

  ret_pop_fsm #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .FLAG_W (FLAG_W)
  ) u_fsm (
    .clk           (clk),
    .reset         (reset),
    .start         (seq_start),
    .start_rti     (wb_rti),
    .pop_word      (wb_pop_word),
    .mem_data      (mem_data),
    .pc_load       (pc_load),
    .pc_value      (pc_value),
    .flags_restore (flags_restore),
    .flags_value   (flags_value),
    .busy          (wb_busy),
`ifdef WB_RETIRE_CNT_EN
    .seq_done      (seq_done)
`else
    .seq_done      ()
`endif
  );

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      retired_count <= '0;
    else if (normal || seq_done)
      retired_count <= retired_count + 32'd1;
  end
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage.
// Directed vectors; monitor checks every cycle.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [2:0]  wb_rdst;
  logic [1:0]  wb_src_select;
  logic [15:0] alu_result;
  logic [15:0] mem_data;
  logic [15:0] in_port;
  logic [15:0] immediate;
  logic        wb_ret;
  logic        wb_rti;
  logic        wb_pop_word;
  logic        rf_write_en;
  logic [2:0]  rf_write_addr;
  logic [15:0] rf_write_data;
  logic        pc_load;
  logic [31:0] pc_value;
  logic        flags_restore;
  logic [2:0]  flags_value;
  logic        wb_busy;
  logic [31:0] retired_count;

  typedef struct {
    string       nm;
    int          due;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        pl;
    logic [31:0] pv;
    logic        fr;
    logic [2:0]  fv;
    logic        bz;
    logic [31:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  writeback_stage dut (
    .clk           (clk),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rdst       (wb_rdst),
    .wb_src_select (wb_src_select),
    .alu_result    (alu_result),
    .mem_data      (mem_data),
    .in_port       (in_port),
    .immediate     (immediate),
    .wb_ret        (wb_ret),
    .wb_rti        (wb_rti),
    .wb_pop_word   (wb_pop_word),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .pc_load       (pc_load),
    .pc_value      (pc_value),
    .flags_restore (flags_restore),
    .flags_value   (flags_value),
    .wb_busy       (wb_busy),
    .retired_count (retired_count)
  );

  // Monitor: outputs are settled 3 time units after the edge.
  always @(posedge clk) begin
    exp_t e;
    #3;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      n_tests++;
      if (rf_write_en !== e.we || rf_write_addr !== e.wa ||
          rf_write_data !== e.wd || pc_load !== e.pl ||
          pc_value !== e.pv || flags_restore !== e.fr ||
          flags_value !== e.fv || wb_busy !== e.bz ||
          retired_count !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: got we=%b wa=%0d wd=%h pl=%b pv=%h fr=%b fv=%b bz=%b cnt=%0d, expected we=%b wa=%0d wd=%h pl=%b pv=%h fr=%b fv=%b bz=%b cnt=%0d",
          e.nm, rf_write_en, rf_write_addr, rf_write_data,
          pc_load, pc_value, flags_restore, flags_value,
          wb_busy, retired_count,
          e.we, e.wa, e.wd, e.pl, e.pv, e.fr, e.fv, e.bz, e.cnt);
      end
    end
  end

  task automatic step(
    input string       nm,
    input logic        r, v, rw,
    input logic [2:0]  rd,
    input logic [1:0]  src,
    input logic [15:0] md,
    input logic        rt, ri, pp,
    input logic        we,
    input logic [2:0]  wa,
    input logic [15:0] wd,
    input logic        pl,
    input logic [31:0] pv,
    input logic        fr,
    input logic [2:0]  fv,
    input logic        bz,
    input int          cnt
  );
    exp_t e;
    reset         = r;
    wb_valid      = v;
    wb_reg_write  = rw;
    wb_rdst       = rd;
    wb_src_select = src;
    mem_data      = md;
    wb_ret        = rt;
    wb_rti        = ri;
    wb_pop_word   = pp;
    e.nm  = nm;
    e.due = cyc + 1;
    e.we  = we;
    e.wa  = wa;
    e.wd  = wd;
    e.pl  = pl;
    e.pv  = pv;
    e.fr  = fr;
    e.fv  = fv;
    e.bz  = bz;
`ifdef WB_RETIRE_CNT_EN
    e.cnt = cnt;
`else
    e.cnt = (cnt == -1) ? 32'd1 : 32'd0;
`endif
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    wb_valid      = 1'b0;
    wb_reg_write  = 1'b0;
    wb_rdst       = 3'd0;
    wb_src_select = 2'b00;
    alu_result    = 16'h1234;
    mem_data      = 16'h0000;
    in_port       = 16'h0F0F;
    immediate     = 16'h0007;
    wb_ret        = 1'b0;
    wb_rti        = 1'b0;
    wb_pop_word   = 1'b0;
    @(posedge clk);
    #1;
    //   name         r  v  rw rd  src  mem       rt ri pp
    //                we wa wd        pl pv            fr fv    bz cnt
    step("reset",     1, 0, 0, 0, 2'b00, 16'h0000, 0, 0, 0,
                      0, 0, 16'h0000, 0, 32'h0,        0, 3'd0, 0, 0);
    step("alu_wr",    0, 1, 1, 5, 2'b00, 16'h0000, 0, 0, 0,
                      1, 5, 16'h1234, 0, 32'h0,        0, 3'd0, 0, 1);
    step("mem_wr",    0, 1, 1, 1, 2'b01, 16'hAAAA, 0, 0, 0,
                      1, 1, 16'hAAAA, 0, 32'h0,        0, 3'd0, 0, 2);
    step("bubble",    0, 0, 1, 7, 2'b00, 16'h5555, 0, 0, 0,
                      0, 1, 16'hAAAA, 0, 32'h0,        0, 3'd0, 0, 2);
    step("in_wr",     0, 1, 1, 2, 2'b10, 16'h0000, 0, 0, 0,
                      1, 2, 16'h0F0F, 0, 32'h0,        0, 3'd0, 0, 3);
    step("imm_wr",    0, 1, 1, 3, 2'b11, 16'h0000, 0, 0, 0,
                      1, 3, 16'h0007, 0, 32'h0,        0, 3'd0, 0, 4);
    step("ret_start", 0, 1, 1, 4, 2'b00, 16'h0000, 1, 0, 0,
                      0, 3, 16'h0007, 0, 32'h0,        0, 3'd0, 1, 4);
    step("ret_low",   0, 0, 0, 0, 2'b00, 16'h0100, 0, 0, 1,
                      0, 3, 16'h0007, 1, 32'h00000100, 0, 3'd0, 0, 5);
    step("ret_after", 0, 0, 0, 0, 2'b00, 16'h0000, 0, 0, 0,
                      0, 3, 16'h0007, 0, 32'h00000100, 0, 3'd0, 0, 5);
    step("rti_start", 0, 1, 0, 0, 2'b00, 16'h0001, 0, 1, 0,
                      0, 3, 16'h0007, 0, 32'h00000100, 0, 3'd0, 1, 5);
    step("rti_gap",   0, 0, 0, 0, 2'b00, 16'hFFFF, 0, 0, 0,
                      0, 3, 16'h0007, 0, 32'h00000100, 0, 3'd0, 1, 5);
    step("rti_low",   0, 0, 0, 0, 2'b00, 16'h0020, 0, 0, 1,
                      0, 3, 16'h0007, 0, 32'h00010020, 0, 3'd0, 1, 5);
    step("rti_flags", 0, 0, 0, 0, 2'b00, 16'h0005, 0, 0, 1,
                      0, 3, 16'h0007, 1, 32'h00010020, 1, 3'd5, 0, 6);
    step("rti_after", 0, 0, 0, 0, 2'b00, 16'h0000, 0, 0, 0,
                      0, 3, 16'h0007, 0, 32'h00010020, 0, 3'd5, 0, 6);
    step("seq2_start",0, 1, 0, 0, 2'b00, 16'h00AB, 1, 0, 0,
                      0, 3, 16'h0007, 0, 32'h00010020, 0, 3'd5, 1, 6);
    step("busy_drop", 0, 1, 1, 6, 2'b00, 16'h0000, 0, 0, 0,
                      0, 3, 16'h0007, 0, 32'h00010020, 0, 3'd5, 1, 6);
    step("mid_reset", 1, 0, 0, 0, 2'b00, 16'h0000, 0, 0, 0,
                      0, 0, 16'h0000, 0, 32'h0,        0, 3'd0, 0, 0);
    step("post_rst",  0, 1, 1, 5, 2'b00, 16'h0000, 0, 0, 0,
                      1, 5, 16'h1234, 0, 32'h0,        0, 3'd0, 0, 1);
    step("both_start",0, 1, 1, 2, 2'b00, 16'h0002, 1, 1, 0,
                      0, 5, 16'h1234, 0, 32'h0,        0, 3'd0, 1, 1);
    step("both_low",  0, 0, 0, 0, 2'b00, 16'h0003, 0, 0, 1,
                      0, 5, 16'h1234, 0, 32'h00020003, 0, 3'd0, 1, 1);
    step("busy_ret",  0, 1, 1, 6, 2'b11, 16'h0009, 1, 0, 0,
                      0, 5, 16'h1234, 0, 32'h00020003, 0, 3'd0, 1, 1);
    step("both_flags",0, 0, 0, 0, 2'b00, 16'h0006, 0, 0, 1,
                      0, 5, 16'h1234, 1, 32'h00020003, 1, 3'd6, 0, 2);
    step("both_after",0, 0, 0, 0, 2'b00, 16'h0000, 0, 0, 0,
                      0, 5, 16'h1234, 0, 32'h00020003, 0, 3'd6, 0, 2);
    for (int i = 0; i < 5 && sbq.size() > 0; i++) begin
      @(posedge clk);
      #4;
    end
    if (sbq.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
